// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
// cdc_pkg : shared types and constants for the CDC handshake receiver
// Rev 1.0
// ============================================================================
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } hs_rx_state_t;

  localparam int MIN_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/cdc_sync_arst.sv
`default_nettype none
// ============================================================================
// cdc_sync_arst : single-bit multi-flop synchronizer, async active-low reset
// Rev 1.0
// ============================================================================
module cdc_sync_arst #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cdc_hs_rx_ctrl.sv
`default_nettype none
// ============================================================================
// cdc_hs_rx_ctrl : destination side of a four-phase req/ack CDC handshake
// Rev 1.0
// ============================================================================
module cdc_hs_rx_ctrl
  import cdc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ack,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_xfer_cnt
);

  generate
    if (STAGES < MIN_STAGES) begin : g_stages_chk
      $error("cdc_hs_rx_ctrl: STAGES must be at least MIN_STAGES");
    end
  endgenerate

  logic              w_req_s;
  logic              w_accept;
  logic              w_err_set;
  hs_rx_state_t      r_state;
  hs_rx_state_t      w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic              r_ack;
  logic              r_err;
  logic              r_err_done;
  logic [CNT_W-1:0]  r_cnt;

  cdc_sync_arst #(
    .STAGES (STAGES)
  ) u_req_sync (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (i_req),
    .o_q  (w_req_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_s) w_state_nxt = VALID;
      end
      VALID: begin
        w_accept  = i_ready;
        // Withdrawn request is flagged once, but the payload is still offered
        w_err_set = !w_req_s && !r_err_done;
        if (i_ready) w_state_nxt = ACK;
      end
      ACK: begin
        if (!w_req_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_err_done <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Capture only once the synchronized request is high, so i_data has settled
      if (r_state == IDLE && w_req_s) r_data <= i_data;
      r_ack      <= (w_state_nxt == ACK);
      r_err      <= w_err_set;
      r_err_done <= (r_state == IDLE) ? 1'b0 : (r_err_done | w_err_set);
      if (w_accept) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_ack      = r_ack;
  assign o_valid    = (r_state == VALID);
  assign o_data     = r_data;
  assign o_busy     = (r_state != IDLE);
  assign o_err      = r_err;
  assign o_xfer_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cdc_hs_rx_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cdc_hs_rx_ctrl : self-checking bench for the CDC handshake receiver
// Rev 1.0
// ============================================================================
module tb_cdc_hs_rx_ctrl;

  localparam int DW = 8;
  localparam int ST = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_req = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_ready = 1'b0;
  logic          o_ack;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_busy;
  logic          o_err;
  logic [CW-1:0] o_xfer_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int n_err_seen = 0;
  logic [DW-1:0] sb_q[$];

  typedef struct {
    logic [DW-1:0] data;
    int            stall;
    bit            abort;
    int            exp_err;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[5];

  cdc_hs_rx_ctrl #(
    .DATA_W (DW),
    .STAGES (ST),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_req      (i_req),
    .i_data     (i_data),
    .o_ack      (o_ack),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .i_ready    (i_ready),
    .o_busy     (o_busy),
    .o_err      (o_err),
    .o_xfer_cnt (o_xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted payload must match the oldest queued one
  always @(negedge clk) begin
    if (rstn) begin
      if (o_err) n_err_seen++;
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got data %0h, expected no transfer", o_data);
        end else begin
          chk("data", 32'(o_data), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_valid && n < 30);
  endtask

  task automatic wait_ack_fall(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (o_ack && n < 30);
  endtask

  task automatic do_xfer(input vec_t v);
    int n;
    int e0;
    e0      = n_err_seen;
    i_data  = v.data;
    sb_q.push_back(v.data);
    i_ready = (v.stall == 0) && !v.abort;
    i_req   = 1'b1;
    wait_valid(n);
    chk("valid_latency", n, 3);
    if (v.abort) begin
      i_req = 1'b0;
      for (int k = 0; k < 8; k++) begin
        tick();
        chk("abort_valid_held", o_valid, 1);
      end
      i_ready = 1'b1;
      tick();
      chk("abort_ack_high", o_ack, 1);
      tick();
      chk("abort_ack_one_cycle", o_ack, 0);
      chk("abort_busy_clear", o_busy, 0);
      i_ready = 1'b0;
    end else begin
      for (int k = 0; k < v.stall; k++) begin
        tick();
        chk("stall_valid", o_valid, 1);
        chk("stall_data", 32'(o_data), 32'(v.data));
        chk("stall_ack_low", o_ack, 0);
      end
      i_ready = 1'b1;
      tick();
      chk("ack_after_accept", o_ack, 1);
      chk("valid_dropped", o_valid, 0);
      i_req   = 1'b0;
      i_ready = 1'b0;
      wait_ack_fall(n);
      chk("ack_fall_latency", n, 3);
    end
    chk("err_pulses", n_err_seen - e0, v.exp_err);
    chk("xfer_cnt", 32'(o_xfer_cnt), 32'(v.exp_cnt));
  endtask

  initial begin
    int   n;
    vec_t w;

    vecs[0] = '{data: 8'hA5, stall: 0,  abort: 1'b0, exp_err: 0, exp_cnt: 4'd2};
    vecs[1] = '{data: 8'h3C, stall: 10, abort: 1'b0, exp_err: 0, exp_cnt: 4'd3};
    vecs[2] = '{data: 8'h5A, stall: 0,  abort: 1'b1, exp_err: 1, exp_cnt: 4'd4};
    vecs[3] = '{data: 8'hC3, stall: 3,  abort: 1'b0, exp_err: 0, exp_cnt: 4'd5};
    vecs[4] = '{data: 8'h0F, stall: 0,  abort: 1'b0, exp_err: 0, exp_cnt: 4'd6};

    // Reset held with request already high
    rstn    = 1'b0;
    i_req   = 1'b1;
    i_data  = 8'h11;
    i_ready = 1'b1;
    repeat (3) tick();
    chk("rst_ack", o_ack, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_err", o_err, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_cnt", 32'(o_xfer_cnt), 0);
    sb_q.push_back(8'h11);
    rstn = 1'b1;
    wait_valid(n);
    chk("post_rst_valid_latency", n, 3);
    tick();
    chk("post_rst_ack", o_ack, 1);
    i_req   = 1'b0;
    i_ready = 1'b0;
    wait_ack_fall(n);
    chk("post_rst_ack_fall", n, 3);
    chk("post_rst_cnt", 32'(o_xfer_cnt), 1);

    for (int i = 0; i < 5; i++) begin
      do_xfer(vecs[i]);
      repeat (2) tick();
    end

    // Counter wrap with back-to-back random transfers
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    chk("wrap_start_cnt", 32'(o_xfer_cnt), 0);
    for (int i = 0; i < 17; i++) begin
      w.data    = 8'($urandom_range(0, 255));
      w.stall   = 0;
      w.abort   = 1'b0;
      w.exp_err = 0;
      w.exp_cnt = 4'((i + 1) % 16);
      do_xfer(w);
    end
    chk("wrap_cnt", 32'(o_xfer_cnt), 1);
    chk("wrap_queue_empty", sb_q.size(), 0);

    // Asynchronous reset while acknowledging
    i_data  = 8'h77;
    sb_q.push_back(8'h77);
    i_ready = 1'b1;
    i_req   = 1'b1;
    wait_valid(n);
    chk("arst_valid_latency", n, 3);
    tick();
    chk("arst_ack_before", o_ack, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_ack", o_ack, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_cnt", 32'(o_xfer_cnt), 0);
    i_req   = 1'b0;
    i_ready = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (4) tick();
    chk("arst_idle_after", o_busy, 0);
    chk("final_queue_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
